data_mem: RTL
=============

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the array.
REQ-002 Parameter LATENCY, default 2, wait cycles between request acceptance and the response state (0 allowed).
REQ-003 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_req_valid  input  1  CPU load/store request present.
REQ-006 o_req_ready  output  1  block can accept a request this cycle.
REQ-007 i_we  input  1  1 = store, 0 = load.
REQ-008 i_addr  input  32  byte address.
REQ-009 i_wdata  input  32  store data, right-aligned.
REQ-010 i_size  input  3  RV32I funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-011 o_rsp_valid  output  1  one-cycle response pulse.
REQ-012 o_rdata  output  32  load result, extended to 32 bits.
REQ-013 o_err  output  1  the transaction faulted; qualified by o_rsp_valid.

Function
REQ-014 The block SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE, with WAIT skipped when LATENCY = 0.
REQ-015 o_req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on the edge where i_req_valid && o_req_ready; i_we, i_addr, i_wdata and i_size SHALL be captured on that edge.
REQ-017 WAIT SHALL last exactly LATENCY cycles, counted by a down-counter of width $clog2(LATENCY+1).
REQ-018 o_rsp_valid SHALL be high for exactly one cycle (RESP), LATENCY+1 cycles after the acceptance edge; there is no response back-pressure.
REQ-019 The next request SHALL be accepted no earlier than the IDLE cycle following RESP, giving a minimum spacing of LATENCY+2 cycles.
REQ-020 The store write and the load read SHALL both occur on the edge entering RESP, so back-to-back store-then-load to the same address returns the new data.
REQ-021 Stores SHALL be little-endian and byte-enabled: SB writes 1 byte, SH writes 2 bytes and SW writes 4 bytes; the other bytes SHALL be unchanged.
REQ-022 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass all 32 bits through.
REQ-023 Error conditions SHALL be:
- halfword access with addr[0] != 0;
- word access with addr[1:0] != 0;
- addr[31:2] >= DEPTH_WORDS;
- size of 3, 6 or 7;
- store with size 4 or 5.
REQ-024 An errored transaction SHALL:
- keep the same timing as a normal one;
- drive o_err = 1 and o_rdata = 0 in RESP;
- leave memory unmodified.
REQ-025 o_rdata and o_err SHALL be 0 whenever o_rsp_valid = 0.
REQ-026 For stores, o_rdata SHALL be 0 in RESP.

Reset
REQ-027 While i_rst is high, o_req_ready, o_rsp_valid, o_rdata and o_err SHALL all be 0, the FSM SHALL be in IDLE and the counter SHALL be 0.
REQ-028 Reset asserted mid-transaction SHALL discard that transaction, and a pending store SHALL NOT be written.
REQ-029 Memory contents SHALL be retained across reset; they are not initialised.
REQ-030 o_req_ready SHALL be 1 in the first cycle after i_rst deasserts.

Structure
REQ-031 The shared package mem_pkg SHALL hold the funct3 size constants and the FSM state encoding, for reuse by the load/store unit.
REQ-032 The byte-enabled word array SHALL be a sub-module data_mem_array (clk, we, 4-bit byte enable, word address, wdata, rdata).
REQ-033 Alignment, lane steering and extension logic SHALL stay in data_mem.

Verification
REQ-034 Reset; then SW 0xDEADBEEF @0x10; then LW @0x10 -> o_rdata = 0xDEADBEEF, o_err = 0, o_rsp_valid exactly 3 cycles after each acceptance (LATENCY = 2).
REQ-035 After REQ-034, SB 0x80 @0x11 -> LW @0x10 = 0xDEAD80EF, LB @0x11 = 0xFFFFFF80, LBU @0x11 = 0x00000080.
REQ-036 LH @0x13 -> o_err = 1, o_rdata = 0; SW @0x12 -> o_err = 1 and word 0x10 unchanged; LW @(DEPTH_WORDS*4) -> o_err = 1.
REQ-037 i_req_valid held high continuously -> o_req_ready low in WAIT/RESP and acceptances exactly 4 cycles apart; repeat with LATENCY = 0 -> 2 cycles apart.
REQ-038 SW 0x12345678 @0x20, i_rst pulsed during WAIT -> outputs 0 during reset, no response pulse, later LW @0x20 returns the prior contents.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared load/store size codes and data memory FSM encoding
package mem_pkg;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - byte-enabled 32-bit word array, synchronous read and write
module data_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // No reset: contents survive i_rst of the parent.
  always_ff @(posedge i_clk) begin
    o_rdata <= r_mem[i_addr];
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - CPU data memory with fixed latency, alignment checks and load extension
module data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_size,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  mem_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_we, r_err;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_size;

  logic          w_accept, w_req_err;
  logic          w_src_we, w_src_err, w_mem_we;
  logic [AW+1:0] w_src_addr;
  logic [31:0]   w_src_wdata, w_st_data, w_rd_raw, w_ld_data;
  logic [2:0]    w_src_size;
  logic [3:0]    w_be;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
  assign w_accept    = i_req_valid && o_req_ready;

  always_comb begin
    w_req_err = 1'b0;
    case (i_size)
      SZ_B, SZ_BU: w_req_err = 1'b0;
      SZ_H, SZ_HU: w_req_err = i_addr[0];
      SZ_W:        w_req_err = |i_addr[1:0];
      default:     w_req_err = 1'b1;
    endcase
    if (i_we && (i_size == SZ_BU || i_size == SZ_HU)) w_req_err = 1'b1;
    if ({2'b00, i_addr[31:2]} >= 32'(DEPTH_WORDS)) w_req_err = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == CW'(1)) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt   <= CW'(LATENCY);
        r_we    <= i_we;
        r_err   <= w_req_err;
        r_addr  <= i_addr[AW+1:0];
        r_wdata <= i_wdata;
        r_size  <= i_size;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // With LATENCY = 0 the array access happens on the acceptance edge itself,
  // so it must use the live request rather than the captured copy.
  assign w_src_we    = (r_state == ST_IDLE) ? i_we : r_we;
  assign w_src_err   = (r_state == ST_IDLE) ? w_req_err : r_err;
  assign w_src_addr  = (r_state == ST_IDLE) ? i_addr[AW+1:0] : r_addr;
  assign w_src_wdata = (r_state == ST_IDLE) ? i_wdata : r_wdata;
  assign w_src_size  = (r_state == ST_IDLE) ? i_size : r_size;
  assign w_mem_we    = (w_state_nxt == ST_RESP) && w_src_we && !w_src_err && !i_rst;

  always_comb begin
    w_be      = 4'b0000;
    w_st_data = w_src_wdata;
    case (w_src_size)
      SZ_B: begin
        w_be      = 4'b0001 << w_src_addr[1:0];
        w_st_data = {4{w_src_wdata[7:0]}};
      end
      SZ_H: begin
        w_be      = w_src_addr[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{w_src_wdata[15:0]}};
      end
      SZ_W:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_mem_we),
    .i_be    (w_be),
    .i_addr  (w_src_addr[AW+1:2]),
    .i_wdata (w_st_data),
    .o_rdata (w_rd_raw)
  );

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = w_rd_raw[7:0];
      2'd1:    w_byte = w_rd_raw[15:8];
      2'd2:    w_byte = w_rd_raw[23:16];
      default: w_byte = w_rd_raw[31:24];
    endcase
  end

  assign w_half = r_addr[1] ? w_rd_raw[31:16] : w_rd_raw[15:0];

  always_comb begin
    case (r_size)
      SZ_B:    w_ld_data = {{24{w_byte[7]}}, w_byte};
      SZ_BU:   w_ld_data = {24'd0, w_byte};
      SZ_H:    w_ld_data = {{16{w_half[15]}}, w_half};
      SZ_HU:   w_ld_data = {16'd0, w_half};
      SZ_W:    w_ld_data = w_rd_raw;
      default: w_ld_data = 32'd0;
    endcase
  end

  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_err       = o_rsp_valid && r_err;
  assign o_rdata     = (o_rsp_valid && !r_err && !r_we) ? w_ld_data : 32'd0;

endmodule
